// File: rtl/tdc_pkg.sv
// Shared widths, event record type and fine-time decode for the multi-channel TDC.
// Delay-line, channel and coarse widths are fixed here so the record type is usable everywhere.
package tdc_pkg;

  localparam int unsigned NumStages = 32;
  localparam int unsigned NumCh     = 4;
  localparam int unsigned CoarseW   = 16;
  localparam int unsigned FineW     = $clog2(NumStages + 1);
  localparam int unsigned ChW       = $clog2(NumCh);

  typedef struct packed {
    logic [ChW-1:0]     channel;
    logic [CoarseW-1:0] coarse;
    logic [FineW-1:0]   fine;
  } tdc_event_t;

  // Counting ones rather than finding the edge tolerates bubbles in the thermometer code.
  function automatic logic [FineW-1:0] popcount(input logic [NumStages-1:0] v);
    logic [FineW-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NumStages; i++) begin
      cnt = cnt + FineW'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/tdc_event_fifo.sv
// Show-ahead FIFO of TDC event records; head entry is visible whenever valid_o is high.
module tdc_event_fifo
  import tdc_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LevelW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  tdc_event_t        data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output tdc_event_t        data_o,
  output logic              full_o,
  output logic [LevelW-1:0] level_o
);

  tdc_event_t        mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              push_ok, pop_ok;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == LevelW'(Depth));
  assign level_o = level_q;
  // Zero the head when empty so the record outputs read as 0 out of reset.
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;

  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && valid_o;

  always_comb begin
    wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + PtrW'(1) : rptr_q;
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tdc_multichannel.sv
// Multi-channel TDC back end: capture, popcount decode, per-channel pending slots and a
// round-robin arbiter feeding a show-ahead event FIFO.
module tdc_multichannel
  import tdc_pkg::*;
#(
  parameter int unsigned FifoDepth = 8,
  localparam int unsigned LevelW = $clog2(FifoDepth + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic [NumCh-1:0]           ch_mask_i,
  input  logic                       drop_clear_i,
  input  logic [NumCh-1:0]           hit_i,
  input  logic [NumCh*NumStages-1:0] taps_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ChW-1:0]             out_channel_o,
  output logic [CoarseW-1:0]         out_coarse_o,
  output logic [FineW-1:0]           out_fine_o,
  output logic [NumCh-1:0]           drop_flags_o,
  output logic [LevelW-1:0]          fifo_level_o
);

  logic [CoarseW-1:0]         cnt_q, cnt_d;
  logic [NumCh-1:0]           s1_hit_q;
  logic [NumCh*NumStages-1:0] s1_taps_q;
  logic [CoarseW-1:0]         s1_cnt_q;
  logic [NumCh-1:0]           s2_hit_q;
  logic [FineW-1:0]           s2_fine_q [NumCh];
  logic [FineW-1:0]           s2_fine_d [NumCh];
  logic [CoarseW-1:0]         s2_cnt_q;
  logic [NumCh-1:0]           pend_full_q, pend_full_d;
  logic [FineW-1:0]           pend_fine_q [NumCh];
  logic [FineW-1:0]           pend_fine_d [NumCh];
  logic [CoarseW-1:0]         pend_coarse_q [NumCh];
  logic [CoarseW-1:0]         pend_coarse_d [NumCh];
  logic [NumCh-1:0]           drop_q, drop_d, drop_set;
  logic [ChW-1:0]             ptr_q, ptr_d;
  logic                       grant_vld;
  logic [ChW-1:0]             grant_idx;
  logic [NumCh-1:0]           grant_oh;
  logic                       fifo_full, fifo_pop, can_push;
  int unsigned                idx;
  tdc_event_t                 push_ev, head_ev;

  assign cnt_d = enable_i ? cnt_q + CoarseW'(1) : cnt_q;

  always_comb begin
    for (int unsigned c = 0; c < NumCh; c++) begin
      s2_fine_d[c] = popcount(s1_taps_q[c*NumStages +: NumStages]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      s1_hit_q  <= '0;
      s1_taps_q <= '0;
      s1_cnt_q  <= '0;
      s2_hit_q  <= '0;
      s2_cnt_q  <= '0;
      for (int unsigned c = 0; c < NumCh; c++) begin
        s2_fine_q[c] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      s1_hit_q  <= hit_i & ch_mask_i & {NumCh{enable_i}};
      s1_taps_q <= taps_i;
      s1_cnt_q  <= cnt_q;
      s2_hit_q  <= s1_hit_q;
      s2_cnt_q  <= s1_cnt_q;
      for (int unsigned c = 0; c < NumCh; c++) begin
        s2_fine_q[c] <= s2_fine_d[c];
      end
    end
  end

  // A pop in the same cycle frees a FIFO entry, so the arbiter may still grant at full.
  assign fifo_pop = out_valid_o && out_ready_i;
  assign can_push = !fifo_full || fifo_pop;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    idx       = 0;
    if (can_push) begin
      for (int unsigned i = 0; i < NumCh; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= NumCh) begin
          idx = idx - NumCh;
        end
        if (!grant_vld && pend_full_q[idx]) begin
          grant_vld = 1'b1;
          grant_idx = ChW'(idx);
        end
      end
    end
    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == ChW'(NumCh - 1)) ? '0 : grant_idx + ChW'(1);
    end
  end

  always_comb begin
    pend_full_d = pend_full_q;
    drop_set    = '0;
    for (int unsigned c = 0; c < NumCh; c++) begin
      pend_fine_d[c]   = pend_fine_q[c];
      pend_coarse_d[c] = pend_coarse_q[c];
      if (s2_hit_q[c]) begin
        if (pend_full_q[c] && !grant_oh[c]) begin
          drop_set[c] = 1'b1;
        end else begin
          pend_full_d[c]   = 1'b1;
          pend_fine_d[c]   = s2_fine_q[c];
          pend_coarse_d[c] = s2_cnt_q;
        end
      end else if (grant_oh[c]) begin
        pend_full_d[c] = 1'b0;
      end
    end
    drop_d = (drop_q & ~{NumCh{drop_clear_i}}) | drop_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_full_q <= '0;
      drop_q      <= '0;
      ptr_q       <= '0;
      for (int unsigned c = 0; c < NumCh; c++) begin
        pend_fine_q[c]   <= '0;
        pend_coarse_q[c] <= '0;
      end
    end else begin
      pend_full_q <= pend_full_d;
      drop_q      <= drop_d;
      ptr_q       <= ptr_d;
      for (int unsigned c = 0; c < NumCh; c++) begin
        pend_fine_q[c]   <= pend_fine_d[c];
        pend_coarse_q[c] <= pend_coarse_d[c];
      end
    end
  end

  always_comb begin
    push_ev.channel = grant_idx;
    push_ev.coarse  = pend_coarse_q[grant_idx];
    push_ev.fine    = pend_fine_q[grant_idx];
  end

  tdc_event_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (grant_vld),
    .data_i (push_ev),
    .pop_i  (fifo_pop),
    .valid_o(out_valid_o),
    .data_o (head_ev),
    .full_o (fifo_full),
    .level_o(fifo_level_o)
  );

  assign out_channel_o = head_ev.channel;
  assign out_coarse_o  = head_ev.coarse;
  assign out_fine_o    = head_ev.fine;
  assign drop_flags_o  = drop_q;

endmodule

// File: doc/tdc_multichannel.md
# tdc_multichannel

Multi-channel timestamping TDC back end, the parametrised successor to the single-channel `tdc`. It takes sampled tapped-delay-line thermometer codes from `NUM_CH` channels and produces `{channel, coarse, fine}` event records. Fine time is the bubble-tolerant tap count; coarse time is a free-running cycle counter. Records from all channels are merged through round-robin arbitration into a FIFO, and the FIFO drains over a valid/ready handshake toward the UART packetiser.

## Interface
- `NUM_STAGES`, 32: taps per delay line; `FINE_W = $clog2(NUM_STAGES+1)`
- `NUM_CH`, 4: channel count, ≥2; `CH_W = $clog2(NUM_CH)`
- `COARSE_W`, 16: coarse counter width
- `FIFO_DEPTH`, 8: event FIFO entries, power of two
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  counter run / hit acceptance
- `ch_mask`  in  NUM_CH  per-channel hit enable
- `drop_clear`  in  1  one-cycle pulse; clears `drop_flags`
- `hit`  in  NUM_CH  per-channel one-cycle hit strobe, synchronous to `clk`
- `taps`  in  NUM_CH*NUM_STAGES  thermometer samples; channel c occupies bits `[c*NUM_STAGES +: NUM_STAGES]`
- `out_valid`  out  1  record available
- `out_ready`  in  1  consumer accepts
- `out_channel`  out  CH_W  source channel
- `out_coarse`  out  COARSE_W  coarse timestamp
- `out_fine`  out  FINE_W  tap count, 0..NUM_STAGES
- `drop_flags`  out  NUM_CH  sticky per-channel overrun
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  current occupancy

## Operation
- Coarse counter `cnt`: increments every cycle while `enable`=1 and holds while 0. Wraps from 2^COARSE_W−1 to 0 with no flag.
- Capture stage S1: registers `hit & ch_mask & {NUM_CH{enable}}`, `taps`, and `cnt`. The captured `cnt` is its pre-increment value at that edge.
- Decode stage S2: `fine = popcount(taps_c)`, which is bubble tolerant. All-zero taps give 0; all-one taps give NUM_STAGES.
- Pending slots: one per channel, loaded from S2.
  - Decoded event arrives while the slot is full and not granted this cycle: the event is discarded and `drop_flags[c]` is set.
  - Slot granted in the same cycle a new event arrives: the new event loads and nothing is dropped.
- Arbiter: round-robin over full pending slots. Pointer starts at channel 0 and moves to grant+1 after each grant. One grant per cycle, and only when the FIFO is not full (a simultaneous pop counts as space).
- FIFO: show-ahead. `out_*` reflect the head entry. A pop occurs when `out_valid && out_ready`.
  - Push to an empty FIFO: `out_valid` rises the next cycle.
  - Push and pop in the same cycle at full: allowed.
- `drop_flags`: cleared by `drop_clear`. If set and clear coincide, set wins.
- `enable` low: counter freezes and new hits are ignored. Pending slots and the FIFO continue to drain.

## Timing
- Hit sampled at edge E0: S1 at E0, pending at E2, FIFO push at E3, `out_valid`=1 after E3. This is the minimum latency of 3 cycles with no contention.
- Contention: N simultaneous hits emerge on N consecutive cycles in round-robin order.
- `out_*` are stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted, including mid-operation: immediately clears `cnt`, pipeline, pending slots, FIFO, pointer, and flags. While reset is active and after release: `out_valid`=0, `out_channel`/`out_coarse`/`out_fine`=0, `drop_flags`=0, `fifo_level`=0.

## Structure
- Package `tdc_pkg`:
  - `tdc_event_t` packed struct `{channel, coarse, fine}`, built from width constants derived from the parameters.
  - `popcount` function.
- Sub-module `tdc_event_fifo`: synchronous show-ahead FIFO of `tdc_event_t` with `level` output.
- Capture, decode, pending slots, and arbiter live in `tdc_multichannel`.

## Test plan
- Reset, `enable`=1, hit ch0 with taps=0x0000_00FF at `cnt`=5 → after 3 cycles one record: ch0, coarse 5, fine 8.
- Bubble taps 0x0000_0F7F on ch1 → fine 11.
- Hits on all 4 channels in the same cycle at `cnt`=20, `out_ready`=1 → records ch0, ch1, ch2, ch3 on consecutive cycles, all coarse 20.
- `out_ready`=0 with 20 hits on ch2 on consecutive cycles → FIFO fills to 8. Pending holds 1 more and later hits drop, so `drop_flags`=4'b0100. Raise `out_ready` → exactly 9 records with coarse strictly increasing. Pulse `drop_clear` → flags 0.
- Run the counter to 0xFFFF and hit on the next cycle → coarse 0x0000 (wrap). Hit with `ch_mask[3]`=0 → no record.
- Assert `reset` low with 3 records queued → `out_valid`=0 and `fifo_level`=0 immediately. After release, the first hit reports the post-reset coarse value.
